t03_mem_request_unit: RTL and testbench

//  Bus-side responder to the t03 single-cycle core's memory requests. Per instruction:

---
 rtl/t03_mem_request_unit.sv | 124 ++++++++++++
 tb/tb_t03_mem_request_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/t03_mem_request_unit.sv
// t03_mem_request_unit: per-instruction fetch and data bus sequencer for the t03 core
module t03_mem_request_unit #(
   parameter logic [31:0] RESET_INST = 32'h0000_0013,
   parameter logic [7:0]  TIMEOUT    = 8'd255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        en,
   input  logic [31:0] pc_in,
   input  logic        read_mem,
   input  logic        write_mem,
   input  logic        load_byte,
   input  logic        store_byte,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_to_write,
   output logic [31:0] instruction,
   output logic [31:0] data_read,
   output logic        i_hit,
   output logic        d_hit,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_adr,
   output logic [31:0] bus_wdat,
   output logic [3:0]  bus_sel,
   input  logic [31:0] bus_rdat,
   input  logic        bus_ack
);
   typedef enum logic [2:0] {IDLE, FETCH, CHECK, DATA, DONE} state_t;
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] instruction_q, instruction_d, data_read_q, data_read_d;
   logic [31:0] bus_adr_q, bus_adr_d, bus_wdat_q, bus_wdat_d;
   logic [3:0]  bus_sel_q, bus_sel_d;
   logic [1:0]  lane_q, lane_d;
   logic        byte_q, byte_d;
   logic        i_hit_q, i_hit_d, d_hit_q, d_hit_d, bus_err_q, bus_err_d;
   logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
   logic        busy, tmo, xfer;
   // a bus phase is open in FETCH/DATA; the timeout acts as a synthetic ack
   assign busy = (state_q == FETCH) || (state_q == DATA);
   assign tmo  = busy && !bus_ack && (TIMEOUT != 8'd0) && (cnt_q == TIMEOUT - 8'd1);
   assign xfer = bus_ack || tmo;
   // state and registered outputs, async reset aborts any transfer in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= 8'd0;
         instruction_q <= RESET_INST;
         data_read_q   <= 32'd0;
         bus_adr_q     <= 32'd0;
         bus_wdat_q    <= 32'd0;
         bus_sel_q     <= 4'd0;
         lane_q        <= 2'd0;
         byte_q        <= 1'b0;
         i_hit_q       <= 1'b0;
         d_hit_q       <= 1'b0;
         bus_err_q     <= 1'b0;
         bus_req_q     <= 1'b0;
         bus_we_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         instruction_q <= instruction_d;
         data_read_q   <= data_read_d;
         bus_adr_q     <= bus_adr_d;
         bus_wdat_q    <= bus_wdat_d;
         bus_sel_q     <= bus_sel_d;
         lane_q        <= lane_d;
         byte_q        <= byte_d;
         i_hit_q       <= i_hit_d;
         d_hit_q       <= d_hit_d;
         bus_err_q     <= bus_err_d;
         bus_req_q     <= bus_req_d;
         bus_we_q      <= bus_we_d;
      end
   end
   // next-state sequencing; write beats read when both are decoded
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = en ? FETCH : IDLE;
         FETCH:   state_d = xfer ? CHECK : FETCH;
         CHECK:   state_d = (write_mem || read_mem) ? DATA : DONE;
         DATA:    state_d = xfer ? DONE : DATA;
         DONE:    state_d = en ? FETCH : IDLE;
         default: state_d = IDLE;
      endcase
   end
   // registered output values, derived from the transition being taken
   always_comb begin
      logic fetch_go, data_go, byte_sel;
      logic [7:0] rd_byte;
      fetch_go      = (state_d == FETCH) && (state_q != FETCH);
      data_go       = (state_q == CHECK) && (state_d == DATA);
      byte_sel      = load_byte || store_byte;
      rd_byte       = bus_rdat[{lane_q, 3'b000} +: 8];
      cnt_d         = (busy && (state_d == state_q)) ? cnt_q + 8'd1 : 8'd0;
      bus_req_d     = (state_d == FETCH) || (state_d == DATA);
      i_hit_d       = state_d == DONE;
      d_hit_d       = (state_d == DONE) && (state_q == DATA);
      bus_err_d     = bus_err_q || tmo;
      bus_we_d      = fetch_go ? 1'b0 : data_go ? write_mem : bus_we_q;
      bus_adr_d     = fetch_go ? {pc_in[31:2], 2'b00} : data_go ? {data_addr[31:2], 2'b00} : bus_adr_q;
      bus_sel_d     = fetch_go ? 4'hF : data_go ? (byte_sel ? 4'b0001 << data_addr[1:0] : 4'hF) : bus_sel_q;
      bus_wdat_d    = data_go ? (byte_sel ? {4{data_to_write[7:0]}} : data_to_write) : bus_wdat_q;
      byte_d        = data_go ? byte_sel : byte_q;
      lane_d        = data_go ? data_addr[1:0] : lane_q;
      instruction_d = (state_q == FETCH && xfer) ? (bus_ack ? bus_rdat : RESET_INST) : instruction_q;
      data_read_d   = (state_q == DATA && tmo) ? 32'd0 :
                      (state_q == DATA && bus_ack && !bus_we_q) ? (byte_q ? {24'd0, rd_byte} : bus_rdat) :
                      data_read_q;
   end
   assign instruction = instruction_q;
   assign data_read   = data_read_q;
   assign i_hit       = i_hit_q;
   assign d_hit       = d_hit_q;
   assign bus_err     = bus_err_q;
   assign bus_req     = bus_req_q;
   assign bus_we      = bus_we_q;
   assign bus_adr     = bus_adr_q;
   assign bus_wdat    = bus_wdat_q;
   assign bus_sel     = bus_sel_q;
endmodule

// File: tb/tb_t03_mem_request_unit.sv
// tb_t03_mem_request_unit: directed checks of fetch, data access, timeout and reset behaviour
module tb_t03_mem_request_unit;
   logic        clock = 1'b0, reset = 1'b1, en = 1'b0;
   logic [31:0] pc_in = 32'd0, data_addr = 32'd0, data_to_write = 32'd0, bus_rdat = 32'd0;
   logic        read_mem = 1'b0, write_mem = 1'b0, load_byte = 1'b0, store_byte = 1'b0, bus_ack = 1'b0;
   logic [31:0] instruction, data_read, bus_adr, bus_wdat;
   logic        i_hit, d_hit, bus_err, bus_req, bus_we;
   logic [3:0]  bus_sel;
   int          n_checks = 0, n_fail = 0;

   t03_mem_request_unit #(.RESET_INST(32'h0000_0013), .TIMEOUT(8'd4)) dut (
      .clock(clock), .reset(reset), .en(en), .pc_in(pc_in), .read_mem(read_mem),
      .write_mem(write_mem), .load_byte(load_byte), .store_byte(store_byte),
      .data_addr(data_addr), .data_to_write(data_to_write), .instruction(instruction),
      .data_read(data_read), .i_hit(i_hit), .d_hit(d_hit), .bus_err(bus_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_adr(bus_adr), .bus_wdat(bus_wdat),
      .bus_sel(bus_sel), .bus_rdat(bus_rdat), .bus_ack(bus_ack)
   );

   always #5 clock = ~clock;

   task automatic wait_req(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus_req) begin
            found = 1'b1;
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic ack_now(input logic [31:0] r);
      bus_ack = 1'b1;
      bus_rdat = r;
      @(negedge clock);
      bus_ack = 1'b0;
      bus_rdat = 32'd0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clock);
      n_checks++; if (instruction !== 32'h13) begin n_fail++; $display("FAIL reset_inst got %h want %h", instruction, 32'h13); end
      n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus_req); end
      n_checks++; if (bus_sel !== 4'h0 || bus_adr !== 32'd0) begin n_fail++; $display("FAIL reset_bus got sel %h adr %h want 0 0", bus_sel, bus_adr); end
      n_checks++; if ({i_hit, d_hit, bus_err} !== 3'b000 || data_read !== 32'd0) begin n_fail++; $display("FAIL reset_flags got %b %h want 000 0", {i_hit, d_hit, bus_err}, data_read); end
      reset = 1'b0;
   endtask

   task automatic test_fetch_nop;
      bit found;
      en = 1'b1;
      pc_in = 32'd0;
      wait_req(found);
      n_checks++; if (!found) begin n_fail++; $display("FAIL t1_req_timeout got none want bus_req"); end
      n_checks++; if (bus_adr !== 32'd0 || bus_we !== 1'b0 || bus_sel !== 4'hF) begin n_fail++; $display("FAIL t1_fetch_bus got %h %b %h want 0 0 f", bus_adr, bus_we, bus_sel); end
      @(negedge clock);
      ack_now(32'h0070_0093);
      n_checks++; if (instruction !== 32'h0070_0093) begin n_fail++; $display("FAIL t1_inst got %h want 00700093", instruction); end
      n_checks++; if (bus_req !== 1'b0 || i_hit !== 1'b0) begin n_fail++; $display("FAIL t1_check got req %b hit %b want 0 0", bus_req, i_hit); end
      @(negedge clock);
      n_checks++; if (i_hit !== 1'b1 || d_hit !== 1'b0) begin n_fail++; $display("FAIL t1_done got %b%b want 10", i_hit, d_hit); end
      pc_in = 32'd4;
      write_mem = 1'b1;
      data_addr = 32'h100;
      data_to_write = 32'hDEAD_BEEF;
   endtask

   task automatic test_store_word;
      @(negedge clock);
      n_checks++; if (i_hit !== 1'b0 || bus_req !== 1'b1 || bus_adr !== 32'd4) begin n_fail++; $display("FAIL t2_fetch got hit %b req %b adr %h want 0 1 4", i_hit, bus_req, bus_adr); end
      ack_now(32'h0011_2023);
      @(negedge clock);
      n_checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_adr !== 32'h100 || bus_sel !== 4'hF || bus_wdat !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t2_data got %b %b %h %h %h want 1 1 100 f deadbeef", bus_req, bus_we, bus_adr, bus_sel, bus_wdat); end
      data_to_write = 32'd0;
      data_addr = 32'h999;
      @(negedge clock);
      n_checks++; if (bus_wdat !== 32'hDEAD_BEEF || bus_adr !== 32'h100 || bus_req !== 1'b1) begin n_fail++; $display("FAIL t2_hold got %h %h %b want deadbeef 100 1", bus_wdat, bus_adr, bus_req); end
      ack_now(32'h0);
      n_checks++; if (i_hit !== 1'b1 || d_hit !== 1'b1 || bus_req !== 1'b0 || data_read !== 32'd0) begin n_fail++; $display("FAIL t2_done got %b%b req %b rd %h want 11 0 0", i_hit, d_hit, bus_req, data_read); end
      write_mem = 1'b0;
      read_mem = 1'b1;
      load_byte = 1'b1;
      data_addr = 32'h103;
      pc_in = 32'd8;
   endtask

   task automatic test_load_byte;
      @(negedge clock);
      n_checks++; if (bus_adr !== 32'd8 || bus_sel !== 4'hF || bus_we !== 1'b0) begin n_fail++; $display("FAIL t3_fetch got %h %h %b want 8 f 0", bus_adr, bus_sel, bus_we); end
      ack_now(32'h1030_4003);
      @(negedge clock);
      n_checks++; if (bus_sel !== 4'b1000 || bus_adr !== 32'h100 || bus_we !== 1'b0) begin n_fail++; $display("FAIL t3_data got %h %h %b want 8 100 0", bus_sel, bus_adr, bus_we); end
      ack_now(32'hA1B2_C3D4);
      n_checks++; if (data_read !== 32'h0000_00A1 || d_hit !== 1'b1) begin n_fail++; $display("FAIL t3_rd got %h dhit %b want 000000a1 1", data_read, d_hit); end
      read_mem = 1'b0;
      load_byte = 1'b0;
      write_mem = 1'b1;
      store_byte = 1'b1;
      data_addr = 32'h201;
      data_to_write = 32'h1234_5677;
   endtask

   task automatic test_store_byte;
      @(negedge clock);
      ack_now(32'h0020_00A3);
      @(negedge clock);
      n_checks++; if (bus_sel !== 4'b0010 || bus_wdat !== 32'h7777_7777 || bus_adr !== 32'h200 || bus_we !== 1'b1) begin n_fail++; $display("FAIL t4_data got %h %h %h %b want 2 77777777 200 1", bus_sel, bus_wdat, bus_adr, bus_we); end
      ack_now(32'hFFFF_FFFF);
      n_checks++; if (data_read !== 32'h0000_00A1 || d_hit !== 1'b1) begin n_fail++; $display("FAIL t4_keep got %h dhit %b want 000000a1 1", data_read, d_hit); end
      store_byte = 1'b0;
      read_mem = 1'b1;
      data_addr = 32'h302;
      data_to_write = 32'hCAFE_F00D;
   endtask

   task automatic test_word_ops;
      @(negedge clock);
      ack_now(32'h0);
      @(negedge clock);
      n_checks++; if (bus_we !== 1'b1 || bus_adr !== 32'h300 || bus_sel !== 4'hF || bus_wdat !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rw_prio got %b %h %h %h want 1 300 f cafef00d", bus_we, bus_adr, bus_sel, bus_wdat); end
      ack_now(32'h0);
      write_mem = 1'b0;
      data_addr = 32'h10;
      @(negedge clock);
      ack_now(32'h0);
      @(negedge clock);
      ack_now(32'h55AA_1234);
      n_checks++; if (data_read !== 32'h55AA_1234 || bus_err !== 1'b0) begin n_fail++; $display("FAIL word_ld got %h err %b want 55aa1234 0", data_read, bus_err); end
      read_mem = 1'b0;
   endtask

   task automatic test_timeout;
      int cnt;
      @(negedge clock);
      cnt = 0;
      while (bus_req && cnt < 10) begin
         cnt++;
         @(negedge clock);
      end
      n_checks++; if (cnt !== 4) begin n_fail++; $display("FAIL fetch_tmo_len got %0d want 4", cnt); end
      n_checks++; if (bus_err !== 1'b1 || instruction !== 32'h13 || i_hit !== 1'b0) begin n_fail++; $display("FAIL fetch_tmo got err %b inst %h hit %b want 1 13 0", bus_err, instruction, i_hit); end
      @(negedge clock);
      n_checks++; if (i_hit !== 1'b1 || d_hit !== 1'b0) begin n_fail++; $display("FAIL fetch_tmo_hit got %b%b want 10", i_hit, d_hit); end
      read_mem = 1'b1;
      data_addr = 32'h40;
      @(negedge clock);
      ack_now(32'h0);
      @(negedge clock);
      cnt = 0;
      while (bus_req && cnt < 10) begin
         cnt++;
         @(negedge clock);
      end
      n_checks++; if (cnt !== 4) begin n_fail++; $display("FAIL data_tmo_len got %0d want 4", cnt); end
      n_checks++; if (data_read !== 32'd0 || i_hit !== 1'b1 || d_hit !== 1'b1 || bus_err !== 1'b1) begin n_fail++; $display("FAIL data_tmo got %h %b%b err %b want 0 11 1", data_read, i_hit, d_hit, bus_err); end
      read_mem = 1'b0;
   endtask

   task automatic test_en_drop;
      @(negedge clock);
      en = 1'b0;
      ack_now(32'h0000_0013);
      @(negedge clock);
      n_checks++; if (i_hit !== 1'b1) begin n_fail++; $display("FAIL en_drop_done got %b want 1", i_hit); end
      repeat (2) @(negedge clock);
      n_checks++; if (bus_req !== 1'b0 || i_hit !== 1'b0) begin n_fail++; $display("FAIL en_drop_idle got req %b hit %b want 0 0", bus_req, i_hit); end
   endtask

   task automatic test_reset_mid;
      bit found;
      en = 1'b1;
      write_mem = 1'b1;
      data_addr = 32'h500;
      wait_req(found);
      n_checks++; if (!found) begin n_fail++; $display("FAIL t6_req_timeout got none want bus_req"); end
      ack_now(32'h0);
      @(negedge clock);
      n_checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin n_fail++; $display("FAIL t6_data got %b %b want 1 1", bus_req, bus_we); end
      #1 reset = 1'b1;
      #1;
      n_checks++; if (bus_req !== 1'b0 || i_hit !== 1'b0 || bus_err !== 1'b0 || instruction !== 32'h13) begin n_fail++; $display("FAIL t6_async got req %b hit %b err %b inst %h want 0 0 0 13", bus_req, i_hit, bus_err, instruction); end
      @(negedge clock);
      n_checks++; if (bus_req !== 1'b0 || i_hit !== 1'b0) begin n_fail++; $display("FAIL t6_held got req %b hit %b want 0 0", bus_req, i_hit); end
      reset = 1'b0;
      write_mem = 1'b0;
      pc_in = 32'h80;
      @(negedge clock);
      n_checks++; if (bus_req !== 1'b1 || bus_adr !== 32'h80 || bus_we !== 1'b0 || i_hit !== 1'b0) begin n_fail++; $display("FAIL t6_restart got req %b adr %h we %b hit %b want 1 80 0 0", bus_req, bus_adr, bus_we, i_hit); end
   endtask

   initial begin
      test_reset;
      test_fetch_nop;
      test_store_word;
      test_load_byte;
      test_store_byte;
      test_word_ops;
      test_timeout;
      test_en_drop;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
